dma_datapath_primitives: RTL and testbench
==========================================

# dma_datapath_primitives

Storage and counting primitives for the DMA controller datapath, grouped in one block: a parameterised synchronous FIFO, an up-counter with parallel load, and a general-purpose enable register. The FIFO buffers words moving between the peripheral and the MSP430 memory backbone. The counter generates word offsets, and the register holds the start address, word count and saved counter values. Each primitive is independent and shares only clock and reset.

## Interface
- DATA, 16: FIFO word width.
- ADDR_SIZE, 5: FIFO depth is 2^ADDR_SIZE words.
- DIV_FACTOR, 3: partial-empty threshold is 2^ADDR_SIZE >> DIV_FACTOR words.
- L, 15: counter width.
- REG_DEPTH, 16: register width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- fifo_enable  in  1  perform the FIFO operation selected by fifo_wr_rd.
- fifo_wr_rd  in  1  1 = write, 0 = read.
- fifo_clr  in  1  synchronous clear of the FIFO.
- fifo_old_add_flag  in  1  retry/cancel of the previous access.
- fifo_in  in  DATA  write data.
- fifo_out  out  DATA  read data, registered.
- full  out  1  occupancy == 2^ADDR_SIZE.
- empty  out  1  occupancy == 0.
- empty_partial  out  1  occupancy <= threshold.
- cnt_en  in  1  counter enable.
- cnt_load  in  1  parallel load; effective only with cnt_en.
- cnt_clr  in  1  synchronous clear of the counter.
- cnt_data_in  in  L  load value.
- cnt  out  L  count.
- end_cnt  out  1  cnt is all ones.
- reg_en  in  1  register load enable.
- reg_clr  in  1  synchronous clear of the register.
- reg_data_in  in  REG_DEPTH  register data.
- reg_data_out  out  REG_DEPTH  register contents.

## Operation
- rst low (asynchronous) forces every register to zero:
  - write pointer, read pointer, occupancy, fifo_out, cnt, reg_data_out all 0;
  - hence empty=1, empty_partial=1, full=0, end_cnt=0.
- FIFO storage:
  - 2^ADDR_SIZE x DATA memory;
  - pointers are ADDR_SIZE bits and wrap modulo depth;
  - occupancy is ADDR_SIZE+1 bits.
- FIFO operations, priority per clock edge: fifo_clr > fifo_old_add_flag > fifo_enable.
  - fifo_clr: pointers and occupancy go to 0; memory contents are don't-care; fifo_out is unchanged.
  - Write (fifo_wr_rd=1, fifo_enable=1, flag=0, not full): mem[wr_ptr] <= fifo_in; wr_ptr+1; occupancy+1.
  - Write when full is ignored: no pointer change and no overwrite.
  - Read (fifo_wr_rd=0, fifo_enable=1, flag=0, not empty): fifo_out <= mem[rd_ptr]; rd_ptr+1; occupancy-1.
  - Read when empty is ignored: fifo_out holds.
  - fifo_old_add_flag=1 with fifo_wr_rd=1: cancels the last write. wr_ptr-1 and occupancy-1 if not empty; no write, whatever fifo_enable is.
  - fifo_old_add_flag=1 with fifo_wr_rd=0: read pointer and fifo_out hold, so the previous word is re-presented; fifo_enable is ignored.
- FIFO flags are combinational from occupancy:
  - full = (occ == 2^ADDR_SIZE);
  - empty = (occ == 0);
  - empty_partial = (occ <= (2^ADDR_SIZE >> DIV_FACTOR)); 4 words at default parameters.
- Counter, priority per clock edge: cnt_clr > (cnt_en & cnt_load) > cnt_en.
  - cnt_clr: cnt <= 0.
  - cnt_en & cnt_load: cnt <= cnt_data_in.
  - cnt_en alone: cnt <= cnt+1, wrapping from all ones to 0.
  - end_cnt = &cnt, combinational.
- Register, priority per clock edge: reg_clr > reg_en.
  - reg_clr: reg_data_out <= 0.
  - reg_en: reg_data_out <= reg_data_in.
  - Otherwise hold.

## Timing
- All state changes happen on the rising edge of clk, except the asynchronous reset.
- rst assertion takes effect immediately; deassertion is sampled on the next rising edge.
- Reset mid-operation discards FIFO contents and counter value.
- FIFO write-to-read latency: a word written at edge N is readable at edge N+1 and appears on fifo_out after that edge.
- Flags are valid in the same cycle the occupancy changes; there is no extra latency.
- Counter and register outputs update one edge after the enables are sampled.
- No combinational path from fifo_in to fifo_out.
- Simultaneous read and write is not supported: one operation per cycle, selected by fifo_wr_rd.

## Test plan
- Reset then fill: assert rst low, release, write 32 words 0x0001..0x0020. empty=1 and empty_partial=1 until the first write; empty_partial=0 after 5 words; full=1 after word 32; a 33rd write is ignored.
- Drain: read 28 words. fifo_out returns 0x0001..0x001C in order; empty_partial rises when 4 words remain; after 4 more reads empty=1 and a further read keeps fifo_out=0x0020.
- Old-address write: write 0xAAAA then 0xBBBB, pulse fifo_old_add_flag with fifo_wr_rd=1, write 0xCCCC. Reads return 0xAAAA, 0xCCCC.
- Old-address read / wrap: with pointers at 30, write 4 words and read them back in order across the wrap. Holding fifo_old_add_flag during a read leaves fifo_out unchanged.
- Counter: cnt_en for 3 cycles gives cnt=3; cnt_load=1 with cnt_en=0 has no effect; cnt_load=1 with cnt_en=1 and data 0x7FFE loads it; one more increment gives end_cnt=1; the next increment wraps to 0; cnt_clr overrides a simultaneous load.
- Register: reg_en with 0x1234 gives 0x1234; it holds when reg_en=0; reg_clr with reg_en gives 0; rst low mid-cycle clears immediately.

Source files
------------

// File: rtl/dma_datapath_primitives.sv
// rtl/dma_datapath_primitives.sv - DMA datapath FIFO, loadable up-counter and enable register
module dma_datapath_primitives #(
  parameter int DATA       = 16,
  parameter int ADDR_SIZE  = 5,
  parameter int DIV_FACTOR = 3,
  parameter int L          = 15,
  parameter int REG_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_enable,
  input  logic                 fifo_wr_rd,
  input  logic                 fifo_clr,
  input  logic                 fifo_old_add_flag,
  input  logic [DATA-1:0]      fifo_in,
  output logic [DATA-1:0]      fifo_out,
  output logic                 full,
  output logic                 empty,
  output logic                 empty_partial,
  input  logic                 cnt_en,
  input  logic                 cnt_load,
  input  logic                 cnt_clr,
  input  logic [L-1:0]         cnt_data_in,
  output logic [L-1:0]         cnt,
  output logic                 end_cnt,
  input  logic                 reg_en,
  input  logic                 reg_clr,
  input  logic [REG_DEPTH-1:0] reg_data_in,
  output logic [REG_DEPTH-1:0] reg_data_out
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]   OCC_FULL = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0]   OCC_PART = (ADDR_SIZE+1)'(DEPTH >> DIV_FACTOR);
  localparam logic [ADDR_SIZE:0]   OCC_ONE  = 1;
  localparam logic [ADDR_SIZE-1:0] PTR_ONE  = 1;
  localparam logic [L-1:0]         CNT_ONE  = 1;

  logic [DATA-1:0]      mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   occ;
  logic                 wr_en;
  logic                 rd_en;

  assign full          = (occ == OCC_FULL);
  assign empty         = (occ == '0);
  assign empty_partial = (occ <= OCC_PART);

  // Clear and the retry/cancel flag both pre-empt a normal access.
  assign wr_en = !fifo_clr && !fifo_old_add_flag && fifo_enable &&  fifo_wr_rd && !full;
  assign rd_en = !fifo_clr && !fifo_old_add_flag && fifo_enable && !fifo_wr_rd && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= fifo_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      fifo_out <= '0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (fifo_old_add_flag) begin
      // Write side rewinds the last word; read side simply holds so the word is re-presented.
      if (fifo_wr_rd && !empty) begin
        wr_ptr <= wr_ptr - PTR_ONE;
        occ    <= occ - OCC_ONE;
      end
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      occ    <= occ + OCC_ONE;
    end else if (rd_en) begin
      fifo_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + PTR_ONE;
      occ      <= occ - OCC_ONE;
    end
  end

  assign end_cnt = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_en && cnt_load) begin
      cnt <= cnt_data_in;
    end else if (cnt_en) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_data_out <= '0;
    end else if (reg_clr) begin
      reg_data_out <= '0;
    end else if (reg_en) begin
      reg_data_out <= reg_data_in;
    end
  end

endmodule

// File: tb/tb_dma_datapath_primitives.sv
// tb/tb_dma_datapath_primitives.sv - scoreboard bench for dma_datapath_primitives
module tb_dma_datapath_primitives;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_enable = 1'b0;
  logic        fifo_wr_rd = 1'b0;
  logic        fifo_clr = 1'b0;
  logic        fifo_old_add_flag = 1'b0;
  logic [15:0] fifo_in = '0;
  logic [15:0] fifo_out;
  logic        full;
  logic        empty;
  logic        empty_partial;
  logic        cnt_en = 1'b0;
  logic        cnt_load = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [14:0] cnt_data_in = '0;
  logic [14:0] cnt;
  logic        end_cnt;
  logic        reg_en = 1'b0;
  logic        reg_clr = 1'b0;
  logic [15:0] reg_data_in = '0;
  logic [15:0] reg_data_out;

  int total = 0;
  int bad = 0;
  logic [15:0] sb[$];
  logic [15:0] last_out = '0;

  dma_datapath_primitives dut (
    .clk(clk), .rst(rst),
    .fifo_enable(fifo_enable), .fifo_wr_rd(fifo_wr_rd), .fifo_clr(fifo_clr),
    .fifo_old_add_flag(fifo_old_add_flag), .fifo_in(fifo_in), .fifo_out(fifo_out),
    .full(full), .empty(empty), .empty_partial(empty_partial),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_clr(cnt_clr), .cnt_data_in(cnt_data_in),
    .cnt(cnt), .end_cnt(end_cnt),
    .reg_en(reg_en), .reg_clr(reg_clr), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".full"}, 32'(full), 32'(sb.size() == 32));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".empty_partial"}, 32'(empty_partial), 32'(sb.size() <= 4));
  endtask

  task automatic fifo_write(input logic [15:0] d);
    fifo_enable = 1'b1; fifo_wr_rd = 1'b1; fifo_in = d;
    tick();
    fifo_enable = 1'b0;
    if (sb.size() < 32) sb.push_back(d);
    chk_flags("wr");
  endtask

  task automatic fifo_read();
    fifo_enable = 1'b1; fifo_wr_rd = 1'b0;
    tick();
    fifo_enable = 1'b0;
    if (sb.size() > 0) last_out = sb.pop_front();
    chk("rd.fifo_out", 32'(fifo_out), 32'(last_out));
    chk_flags("rd");
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.empty_partial", 32'(empty_partial), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.fifo_out", 32'(fifo_out), 32'd0);
    chk("rst.cnt", 32'(cnt), 32'd0);
    chk("rst.end_cnt", 32'(end_cnt), 32'd0);
    chk("rst.reg", 32'(reg_data_out), 32'd0);
    rst = 1'b1;
    tick();

    // Fill to full, then an ignored 33rd write
    for (int i = 1; i <= 32; i++) fifo_write(16'(i));
    chk("fill.full", 32'(full), 32'd1);
    fifo_write(16'h0033);
    chk("fill33.full", 32'(full), 32'd1);

    // Drain 28, then 4 more, then a read on empty
    for (int i = 0; i < 28; i++) fifo_read();
    chk("drain28.empty_partial", 32'(empty_partial), 32'd1);
    for (int i = 0; i < 4; i++) fifo_read();
    chk("drain32.empty", 32'(empty), 32'd1);
    fifo_read();
    chk("drain_empty.fifo_out", 32'(fifo_out), 32'h0020);

    // Cancel on empty FIFO does nothing
    fifo_old_add_flag = 1'b1; fifo_wr_rd = 1'b1; fifo_enable = 1'b1; fifo_in = 16'h5A5A;
    tick();
    fifo_old_add_flag = 1'b0; fifo_enable = 1'b0;
    chk_flags("cancel_empty");

    // Old-address write cancels BBBB
    fifo_write(16'hAAAA);
    fifo_write(16'hBBBB);
    fifo_old_add_flag = 1'b1; fifo_wr_rd = 1'b1; fifo_enable = 1'b1; fifo_in = 16'hDDDD;
    tick();
    fifo_old_add_flag = 1'b0; fifo_enable = 1'b0;
    void'(sb.pop_back());
    chk_flags("cancel");
    fifo_write(16'hCCCC);
    fifo_read();
    chk("oldw.first", 32'(fifo_out), 32'hAAAA);
    fifo_read();
    chk("oldw.second", 32'(fifo_out), 32'hCCCC);

    // Advance pointers from 2 to 30, then wrap
    for (int i = 0; i < 28; i++) fifo_write(16'($urandom_range(0, 16'hFFFF)));
    for (int i = 0; i < 28; i++) fifo_read();
    for (int i = 0; i < 4; i++) fifo_write(16'h1000 + 16'(i));
    for (int i = 0; i < 4; i++) fifo_read();
    chk("wrap.last", 32'(fifo_out), 32'h1003);

    // Old-address read holds fifo_out and the read pointer
    fifo_write(16'h2222);
    fifo_write(16'h3333);
    fifo_read();
    fifo_old_add_flag = 1'b1; fifo_wr_rd = 1'b0; fifo_enable = 1'b1;
    tick(); tick();
    fifo_old_add_flag = 1'b0; fifo_enable = 1'b0;
    chk("oldr.hold", 32'(fifo_out), 32'h2222);
    chk_flags("oldr");
    fifo_read();

    // Clear keeps fifo_out
    fifo_write(16'h4444);
    fifo_write(16'h5555);
    fifo_clr = 1'b1; fifo_enable = 1'b1; fifo_wr_rd = 1'b1; fifo_in = 16'h6666;
    tick();
    fifo_clr = 1'b0; fifo_enable = 1'b0;
    sb.delete();
    chk_flags("clr");
    chk("clr.fifo_out", 32'(fifo_out), 32'h3333);
    fifo_write(16'h7777);
    fifo_read();

    // Counter
    cnt_en = 1'b1;
    tick(); tick(); tick();
    cnt_en = 1'b0;
    chk("cnt.three", 32'(cnt), 32'd3);
    cnt_load = 1'b1; cnt_data_in = 15'h1234;
    tick();
    chk("cnt.load_no_en", 32'(cnt), 32'd3);
    cnt_en = 1'b1; cnt_data_in = 15'h7FFE;
    tick();
    cnt_load = 1'b0;
    chk("cnt.load", 32'(cnt), 32'h7FFE);
    chk("cnt.load_end", 32'(end_cnt), 32'd0);
    tick();
    chk("cnt.max", 32'(cnt), 32'h7FFF);
    chk("cnt.end", 32'(end_cnt), 32'd1);
    tick();
    chk("cnt.wrap", 32'(cnt), 32'd0);
    chk("cnt.wrap_end", 32'(end_cnt), 32'd0);
    tick();
    chk("cnt.one", 32'(cnt), 32'd1);
    cnt_clr = 1'b1; cnt_load = 1'b1; cnt_data_in = 15'h0055;
    tick();
    cnt_clr = 1'b0; cnt_load = 1'b0; cnt_en = 1'b0;
    chk("cnt.clr_over_load", 32'(cnt), 32'd0);

    // Register
    reg_en = 1'b1; reg_data_in = 16'h1234;
    tick();
    chk("reg.load", 32'(reg_data_out), 32'h1234);
    reg_en = 1'b0; reg_data_in = 16'h5555;
    tick();
    chk("reg.hold", 32'(reg_data_out), 32'h1234);
    reg_en = 1'b1; reg_clr = 1'b1;
    tick();
    reg_clr = 1'b0;
    chk("reg.clr", 32'(reg_data_out), 32'd0);
    reg_data_in = 16'hBEEF;
    tick();
    reg_en = 1'b0;
    chk("reg.beef", 32'(reg_data_out), 32'hBEEF);

    // Asynchronous reset mid-cycle
    cnt_en = 1'b1;
    fifo_write(16'h9999);
    cnt_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("arst.reg", 32'(reg_data_out), 32'd0);
    chk("arst.cnt", 32'(cnt), 32'd0);
    chk_flags("arst");
    tick();
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
